// File: rtl/mas_rca_seq_add_ctrl.sv
// Sequential wide adder. It reuses one 32-bit ripple-carry adder over WORDS
// cycles, starting with the least significant word. The carry passes from one
// word to the next through a register.
// Optional feature macro: MAS_SEQ_ADD_SUB_EN adds the sub port (A - B mode).
module mas_rca_seq_add_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in1,
  input  logic [32*WORDS-1:0]   in2,
  input  logic                  cin,
`ifdef MAS_SEQ_ADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   res,
  output logic                  cout,
  output logic                  busy
);

  localparam int unsigned W    = 32 * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;

  logic [W-1:0]    b_load;
  logic            carry_load;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [31:0]     add_sum;
  logic            add_cout;

  // Values loaded on accept. Subtraction is A + ~B + 1.
`ifdef MAS_SEQ_ADD_SUB_EN
  always_comb begin
    b_load     = sub ? ~in2 : in2;
    carry_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load     = in2;
    carry_load = cin;
  end
`endif

  // Shared 32-bit ripple-carry adder working on the word selected by idx_q.
  always_comb begin
    logic c;
    add_a   = a_q[32*idx_q +: 32];
    add_b   = b_q[32*idx_q +: 32];
    add_sum = '0;
    c       = carry_q;
    for (int i = 0; i < 32; i++) begin
      add_sum[i] = add_a[i] ^ add_b[i] ^ c;
      c          = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
    end
    add_cout = c;
  end

  // Control FSM. All outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            a_q      <= in1;
            b_q      <= b_load;
            carry_q  <= carry_load;
            idx_q    <= '0;
            res      <= '0;
            cout     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= StRun;
          end
        end
        StRun: begin
          res[32*idx_q +: 32] <= add_sum;
          carry_q             <= add_cout;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_q     <= '0;
            cout      <= add_cout;
            out_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          // in_valid is ignored here. A new accept can only happen from StIdle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mas_rca_seq_add_ctrl.sv
// Self-checking bench for mas_rca_seq_add_ctrl (WORDS=4). A scoreboard queue
// holds the expected {cout, res} for each operation the bench issues.
module tb_mas_rca_seq_add_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  typedef logic [W:0] val_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
  logic         cout;
  logic         busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  val_t exp_q[$];
  val_t last_exp;

  always #5 clk = ~clk;

  mas_rca_seq_add_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
`ifdef MAS_SEQ_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input val_t obs, input val_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Compute the reference result from the operands.
  function automatic val_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    logic [W-1:0] bb;
    logic         cc;
    bb = s ? ~b : b;
    cc = s ? 1'b1 : c;
    return {1'b0, a} + {1'b0, bb} + val_t'(cc);
  endfunction

  // Present one operation, push its expected result, and return after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_eq("issue_timeout", val_t'(in_ready), val_t'(1));
      return;
    end
    in1 = a; in2 = b; cin = c; sub = s; in_valid = 1'b1;
    exp_q.push_back(model(a, b, c, s));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid and check the latency and the result. Does not hand the result off.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, val_t'(lat), val_t'(WORDS));
    if (!out_valid) return;
    check_eq({tag, "_busy"}, val_t'(busy), val_t'(1));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, val_t'(0), val_t'(1));
      return;
    end
    last_exp = exp_q.pop_front();
    check_eq({tag, "_res"}, {cout, res}, last_exp);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_ov_clr"}, val_t'(out_valid), val_t'(0));
    check_eq({tag, "_rdy"}, val_t'(in_ready), val_t'(1));
    check_eq({tag, "_idle"}, val_t'(busy), val_t'(0));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    ones = '1;

    // Check the state while reset is held.
    @(negedge clk);
    check_eq("rst_res", val_t'(res), val_t'(0));
    check_eq("rst_cout", val_t'(cout), val_t'(0));
    check_eq("rst_ov", val_t'(out_valid), val_t'(0));
    check_eq("rst_rdy", val_t'(in_ready), val_t'(1));
    check_eq("rst_busy", val_t'(busy), val_t'(0));
    rst = 1'b0;
    @(negedge clk);

    // Carry propagates through every word.
    issue(ones, 128'd1, 1'b0, 1'b0);
    wait_result("chain");
    handoff("chain");

    // Carry-in alone.
    issue(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, '0, 1'b1, 1'b0);
    wait_result("cin");
    handoff("cin");

    // Backpressure. A new request sent during DONE must be ignored.
    issue(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'hF0F0_F0F0_0000_0001_FFFF_FFFF_1111_1111,
          1'b1, 1'b0);
    wait_result("bp");
    in1 = 128'hDEAD_BEEF_0000_0000_CAFE_F00D_0000_0007;
    in2 = 128'h0000_0001_FFFF_FFFF_0000_0001_0000_0009;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold_res", {cout, res}, last_exp);
      check_eq("bp_hold_rdy", val_t'(in_ready), val_t'(0));
      check_eq("bp_hold_ov", val_t'(out_valid), val_t'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_ov_clr", val_t'(out_valid), val_t'(0));
    check_eq("bp_idle_rdy", val_t'(in_ready), val_t'(1));
    // in_valid is still high, so the held request is accepted on this edge.
    exp_q.push_back(model(in1, in2, cin, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_accept", val_t'(in_ready), val_t'(0));
    wait_result("bp2");
    handoff("bp2");

    // Asynchronous reset during RUN cancels the operation.
    issue(128'd3, 128'd4, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_res", val_t'(res), val_t'(0));
    check_eq("abort_cout", val_t'(cout), val_t'(0));
    check_eq("abort_ov", val_t'(out_valid), val_t'(0));
    check_eq("abort_rdy", val_t'(in_ready), val_t'(1));
    check_eq("abort_busy", val_t'(busy), val_t'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < WORDS + 2; i++) begin
      @(negedge clk);
      check_eq("abort_no_ov", val_t'(out_valid), val_t'(0));
    end
    issue(128'd5, 128'd6, 1'b0, 1'b0);
    wait_result("post_abort");
    handoff("post_abort");

`ifdef MAS_SEQ_ADD_SUB_EN
    issue(128'd5, 128'd7, 1'b1, 1'b1);
    wait_result("sub_borrow");
    handoff("sub_borrow");
    issue(128'd7, 128'd5, 1'b0, 1'b1);
    wait_result("sub_ok");
    handoff("sub_ok");
`endif

    // Random operands.
    for (int n = 0; n < 6; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, 1'b0);
      wait_result("rand");
      handoff("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
